// File: rtl/world_map_pkg.sv
// Shared types for the world-map ROM arbiter: map geometry, return-tag layout and FSM states.
package world_map_pkg;

    localparam int MAP_ADDR_W = 14;
    localparam int MAP_DATA_W = 2;
    localparam int SNS_ID_W   = 3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_SNS  = 2'd2
    } owner_t;

    // stolen marks a sensor read that displaced a video request; video still gets a (stalled) return
    typedef struct packed {
        owner_t                owner;
        logic [SNS_ID_W-1:0]   sns_id;
        logic                  stolen;
    } ret_tag_t;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/world_map_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/world_map_arbiter.sv
// Shares the single-port world-map ROM between the video path and NUM_SNS sensors; video wins
// unless a sensor has been refused MAX_WAIT cycles, in which case one video slot is stolen.
module world_map_arbiter
    import world_map_pkg::*;
#(
    parameter int NUM_SNS  = 4,
    parameter int ROM_LAT  = 1,
    parameter int MAX_WAIT = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          vid_req,
    input  logic [MAP_ADDR_W-1:0]         vid_addr,
    output logic [MAP_DATA_W-1:0]         vid_data,
    output logic                          vid_dvalid,
    output logic                          vid_stall,
    input  logic [NUM_SNS-1:0]            sns_req,
    input  logic [NUM_SNS*MAP_ADDR_W-1:0] sns_addr,
    output logic [NUM_SNS-1:0]            sns_gnt,
    output logic [MAP_DATA_W-1:0]         sns_data,
    output logic [NUM_SNS-1:0]            sns_dvalid,
    output logic [MAP_ADDR_W-1:0]         rom_addr,
    input  logic [MAP_DATA_W-1:0]         rom_data
);
    localparam int                  WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [SNS_ID_W-1:0] LAST_ID  = SNS_ID_W'(NUM_SNS - 1);

    arb_state_t            state_q, state_d;
    logic [SNS_ID_W-1:0]   ptr_q, ptr_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [MAP_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [NUM_SNS-1:0]    sns_gnt_q, sns_gnt_d;
    logic [MAP_DATA_W-1:0] vid_hold_q, vid_hold_d;
    ret_tag_t              tag_q [0:ROM_LAT];
    ret_tag_t              tag_d [0:ROM_LAT];
    ret_tag_t              ret_tag;

    logic [NUM_SNS-1:0]    rr_gnt;
    logic [SNS_ID_W-1:0]   sel_id;
    logic [MAP_ADDR_W-1:0] sel_addr;
    logic                  any_sns;
    logic                  force_slot;
    logic                  sns_win;

    rr_arbiter #(
        .NUM_REQ (NUM_SNS),
        .PTR_W   (SNS_ID_W)
    ) u_rr (
        .req (sns_req),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_SNS; i++) begin
            if (rr_gnt[i]) begin
                sel_id   = SNS_ID_W'(i);
                sel_addr = sns_addr[i*MAP_ADDR_W +: MAP_ADDR_W];
            end
        end
    end

    always_comb begin
        any_sns    = |sns_req;
        force_slot = (state_q == ST_FORCE) && any_sns;
        sns_win    = force_slot || (!vid_req && any_sns);
        rom_addr_d = rom_addr_q;
        sns_gnt_d  = '0;
        ptr_d      = ptr_q;
        tag_d[0]   = '0;
        if (sns_win) begin
            rom_addr_d       = sel_addr;
            sns_gnt_d        = rr_gnt;
            ptr_d            = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
            tag_d[0].owner   = OWN_SNS;
            tag_d[0].sns_id  = sel_id;
            tag_d[0].stolen  = vid_req;
        end else if (vid_req) begin
            rom_addr_d     = vid_addr;
            tag_d[0].owner = OWN_VID;
        end
        for (int k = 1; k <= ROM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        // Counter tracks consecutive refusals of any pending sensor request
        if (!any_sns || sns_win) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end

        state_d = state_q;
        case (state_q)
            ST_NORMAL: if (wait_d == WAIT_MAX) state_d = ST_FORCE;
            ST_FORCE:  state_d = ST_NORMAL;
            default:   state_d = ST_NORMAL;
        endcase
    end

    // Return side: the last tag stage lines up with rom_data
    always_comb begin
        ret_tag    = tag_q[ROM_LAT];
        vid_dvalid = (ret_tag.owner == OWN_VID) || ret_tag.stolen;
        vid_stall  = ret_tag.stolen;
        vid_data   = (ret_tag.owner == OWN_VID) ? rom_data : vid_hold_q;
        vid_hold_d = vid_data;
        sns_data   = (ret_tag.owner == OWN_SNS) ? rom_data : '0;
    end

    for (genvar gi = 0; gi < NUM_SNS; gi++) begin : g_dvalid
        assign sns_dvalid[gi] = (ret_tag.owner == OWN_SNS) && (ret_tag.sns_id == SNS_ID_W'(gi));
    end

    assign rom_addr = rom_addr_q;
    assign sns_gnt  = sns_gnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_NORMAL;
            ptr_q      <= '0;
            wait_q     <= '0;
            rom_addr_q <= '0;
            sns_gnt_q  <= '0;
            vid_hold_q <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wait_q     <= wait_d;
            rom_addr_q <= rom_addr_d;
            sns_gnt_q  <= sns_gnt_d;
            vid_hold_q <= vid_hold_d;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

endmodule

// File: tb/tb_world_map_arbiter.sv
// Randomized and directed checks of world_map_arbiter against an event-scheduling reference model.
module tb_world_map_arbiter;

    localparam int N     = 4;
    localparam int LAT   = 1;
    localparam int MW    = 16;
    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        vid_req = 1'b0;
    logic [13:0] vid_addr = '0;
    logic [3:0]  sns_req = '0;
    logic [55:0] sns_addr = '0;

    logic [1:0]  vid_data, sns_data, rom_data;
    logic        vid_dvalid, vid_stall;
    logic [3:0]  sns_gnt, sns_dvalid;
    logic [13:0] rom_addr;

    logic [1:0]  v3_data, s3_data, rom3_data;
    logic        v3_dvalid, v3_stall;
    logic [3:0]  s3_gnt, s3_dvalid;
    logic [13:0] rom3_addr;

    logic [1:0]  rom_d1 = '0;
    logic [1:0]  rom3_a = '0, rom3_b = '0, rom3_c = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    int          ev_gnt  [DEPTH];
    bit          ev_aset [DEPTH];
    logic [13:0] ev_addr [DEPTH];
    int          ev_kind [DEPTH];
    int          ev_id   [DEPTH];
    logic [13:0] ev_raddr[DEPTH];
    bit          ev_stol [DEPTH];
    int          m_ptr, m_wait;
    logic [13:0] cur_addr;
    logic [1:0]  last_vid;
    logic [27:0] obs_vec, exp_vec;

    function automatic logic [1:0] rom_fn(input logic [13:0] a);
        return a[1:0] ^ a[8:7] ^ a[13:12];
    endfunction

    world_map_arbiter #(.NUM_SNS(N), .ROM_LAT(LAT), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset_n(reset_n), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_data(vid_data), .vid_dvalid(vid_dvalid), .vid_stall(vid_stall),
        .sns_req(sns_req), .sns_addr(sns_addr), .sns_gnt(sns_gnt), .sns_data(sns_data),
        .sns_dvalid(sns_dvalid), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    world_map_arbiter #(.NUM_SNS(N), .ROM_LAT(3), .MAX_WAIT(MW)) dut3 (
        .clk(clk), .reset_n(reset_n), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_data(v3_data), .vid_dvalid(v3_dvalid), .vid_stall(v3_stall),
        .sns_req(sns_req), .sns_addr(sns_addr), .sns_gnt(s3_gnt), .sns_data(s3_data),
        .sns_dvalid(s3_dvalid), .rom_addr(rom3_addr), .rom_data(rom3_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_d1 <= rom_fn(rom_addr);
        rom3_a <= rom_fn(rom3_addr);
        rom3_b <= rom3_a;
        rom3_c <= rom3_b;
    end
    assign rom_data  = rom_d1;
    assign rom3_data = rom3_c;

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            ev_gnt[i] = -1; ev_aset[i] = 1'b0; ev_addr[i] = '0;
            ev_kind[i] = 0; ev_id[i] = 0; ev_raddr[i] = '0; ev_stol[i] = 1'b0;
        end
        m_ptr = 0; m_wait = 0; cur_addr = '0; last_vid = '0;
    endtask

    // Apply the arbitration rules to this cycle's inputs, advance one clock, build expectations.
    task automatic tick();
        int c, id;
        logic [13:0] a;
        logic [55:0] sh;
        logic [1:0]  rd;
        c = cyc;
        if (reset_n) begin
            if ((sns_req != 0) && (m_wait >= MW || !vid_req)) begin
                id = -1;
                for (int k = 0; k < N; k++) begin
                    if (id < 0 && ((sns_req >> ((m_ptr + k) % N)) & 4'd1) != 0) id = (m_ptr + k) % N;
                end
                sh = sns_addr >> (14 * id);
                a  = sh[13:0];
                ev_gnt[c+1] = id; ev_aset[c+1] = 1'b1; ev_addr[c+1] = a;
                ev_kind[c+1+LAT] = 2; ev_id[c+1+LAT] = id; ev_raddr[c+1+LAT] = a;
                ev_stol[c+1+LAT] = vid_req;
                m_ptr  = (id + 1) % N;
                m_wait = 0;
            end else begin
                if (vid_req) begin
                    ev_aset[c+1] = 1'b1; ev_addr[c+1] = vid_addr;
                    ev_kind[c+1+LAT] = 1; ev_raddr[c+1+LAT] = vid_addr;
                end
                m_wait = (sns_req != 0) ? ((m_wait < MW) ? m_wait + 1 : MW) : 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        c = cyc;
        if (ev_aset[c]) cur_addr = ev_addr[c];
        rd = rom_fn(ev_raddr[c]);
        if (ev_kind[c] == 1) last_vid = rd;
        exp_vec = {last_vid, (ev_kind[c] == 1) || ev_stol[c], ev_stol[c],
                   (ev_gnt[c] >= 0) ? 4'(1 << ev_gnt[c]) : 4'd0,
                   (ev_kind[c] == 2) ? rd : 2'd0,
                   (ev_kind[c] == 2) ? 4'(1 << ev_id[c]) : 4'd0,
                   cur_addr};
        obs_vec = {vid_data, vid_dvalid, vid_stall, sns_gnt, sns_data, sns_dvalid, rom_addr};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        vid_req = 1'b1; vid_addr = 14'h0ABC;
        sns_req = 4'b1111; sns_addr = {$urandom, $urandom};
        clear_model();
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            total++;
            if (obs_vec !== 28'd0) begin bad++; $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, obs_vec); end
        end
        reset_n = 1'b1; vid_req = 1'b0; sns_req = '0;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if ({vid_dvalid, sns_dvalid} !== 5'd0) begin bad++; $display("FAIL reset_release_dvalid cyc=%0d got=%b exp=0", cyc, {vid_dvalid, sns_dvalid}); end
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL reset_release_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_video();
        vid_req = 1'b1; vid_addr = 14'h1234;
        tick();
        total++;
        if (rom_addr !== 14'h1234) begin bad++; $display("FAIL video_rom_addr got=%h exp=1234", rom_addr); end
        vid_req = 1'b0;
        tick();
        total++;
        if (!vid_dvalid || vid_data !== rom_fn(14'h1234)) begin
            bad++; $display("FAIL video_return got dv=%b d=%h exp dv=1 d=%h", vid_dvalid, vid_data, rom_fn(14'h1234));
        end
        for (int n = 0; n < 10; n++) begin
            vid_req = $urandom_range(0, 1) == 1; vid_addr = 14'($urandom);
            tick();
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL video_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        vid_req = 1'b0;
    endtask

    task automatic test_round_robin();
        sns_req = 4'b1111; sns_addr = {$urandom, $urandom};
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n == 5) sns_req = '0;
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            if (n <= 5) begin
                total++;
                if (sns_gnt !== 4'(1 << ((n - 1) % 4))) begin bad++; $display("FAIL rr_gnt tick=%0d got=%b exp=%b", n, sns_gnt, 4'(1 << ((n - 1) % 4))); end
            end
            if (n >= 2) begin
                total++;
                if (sns_dvalid !== 4'(1 << ((n - 2) % 4))) begin bad++; $display("FAIL rr_dvalid tick=%0d got=%b exp=%b", n, sns_dvalid, 4'(1 << ((n - 2) % 4))); end
            end
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL rr_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_starvation();
        logic [13:0] ah [0:24];
        logic [1:0]  vd [0:24];
        logic        st [0:24];
        logic        dv [0:24];
        int gnt_at = -1;
        vid_req = 1'b1; sns_req = 4'b0100; sns_addr = {$urandom, $urandom};
        for (int n = 1; n <= 22; n++) begin
            vid_addr = 14'($urandom); ah[n] = vid_addr;
            tick();
            vd[n] = vid_data; st[n] = vid_stall; dv[n] = vid_dvalid;
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL starve_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            if (sns_gnt[2] && gnt_at < 0) begin gnt_at = n; sns_req = '0; end
        end
        total++;
        if (gnt_at != 17) begin bad++; $display("FAIL starve_grant_tick got=%0d exp=17", gnt_at); end
        total++;
        if (!(st[18] && dv[18] && vd[18] === rom_fn(ah[16]))) begin
            bad++; $display("FAIL starve_stolen_slot got st=%b dv=%b d=%h exp st=1 dv=1 d=%h", st[18], dv[18], vd[18], rom_fn(ah[16]));
        end
        total++;
        if (!(!st[19] && dv[19] && vd[19] === rom_fn(ah[18]))) begin
            bad++; $display("FAIL starve_next_slot got st=%b dv=%b d=%h exp st=0 dv=1 d=%h", st[19], dv[19], vd[19], rom_fn(ah[18]));
        end
    endtask

    task automatic test_withdraw();
        int gnt_at = -1;
        vid_req = 1'b1; sns_req = 4'b0010;
        for (int n = 1; n <= 6; n++) begin
            if (n == 4) sns_req = '0;
            vid_addr = 14'($urandom);
            tick();
            total++;
            if (sns_gnt[1] !== 1'b0 || obs_vec !== exp_vec) begin bad++; $display("FAIL withdraw_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        sns_req = 4'b0010;
        for (int n = 1; n <= 20; n++) begin
            vid_addr = 14'($urandom);
            tick();
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL withdraw_retry_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            if (sns_gnt[1] && gnt_at < 0) begin gnt_at = n; sns_req = '0; end
        end
        total++;
        if (gnt_at != 17) begin bad++; $display("FAIL withdraw_wait_cleared grant_tick got=%0d exp=17", gnt_at); end
        vid_req = 1'b0;
    endtask

    task automatic test_random(input int n_cycles);
        for (int n = 0; n < n_cycles; n++) begin
            vid_req  = $urandom_range(0, 9) < 7;
            vid_addr = 14'($urandom);
            for (int i = 0; i < N; i++) begin
                if (sns_req[i]) begin
                    if (sns_gnt[i] ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0)) sns_req[i] = 1'b0;
                end else if ($urandom_range(0, 9) < 2) begin
                    sns_req[i] = 1'b1;
                    sns_addr[i*14 +: 14] = 14'($urandom);
                end
            end
            tick();
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        vid_req = 1'b0; sns_req = '0;
        for (int n = 0; n < LAT + 2; n++) begin
            tick();
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_reset_inflight();
        int seen = -1;
        logic [1:0] d3 = '0;
        vid_req = 1'b0; sns_req = '0;
        for (int n = 0; n < 4; n++) tick();
        vid_req = 1'b1; vid_addr = 14'h2A5C;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n == 1) vid_req = 1'b0;
            if (v3_dvalid && seen < 0) begin seen = n; d3 = v3_data; end
        end
        total++;
        if (seen != 4 || d3 !== rom_fn(14'h2A5C)) begin bad++; $display("FAIL lat3_return tick got=%0d d=%h exp tick=4 d=%h", seen, d3, rom_fn(14'h2A5C)); end
        vid_req = 1'b1; vid_addr = 14'h1B3E;
        tick();
        vid_req = 1'b0;
        tick();
        reset_n = 1'b0;
        clear_model();
        for (int n = 0; n < 2; n++) begin
            tick();
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL inflight_reset_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        reset_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            total++;
            if ({v3_dvalid, s3_dvalid} !== 5'd0) begin bad++; $display("FAIL inflight_dvalid cyc=%0d got=%b exp=0", cyc, {v3_dvalid, s3_dvalid}); end
            total++;
            if (obs_vec !== exp_vec) begin bad++; $display("FAIL inflight_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_video();
        test_round_robin();
        test_starvation();
        test_withdraw();
        test_random(1500);
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
